// File: rtl/alu_pkg.sv
// Shared widths, opcodes and FSM encoding for the ALU issue stage.
package alu_pkg;

    localparam int unsigned ALU_WIDTH = 4;
    localparam int unsigned ALU_SEL_W = 3;

    localparam logic [ALU_SEL_W-1:0] OP_ADD = 3'b000;
    localparam logic [ALU_SEL_W-1:0] OP_SUB = 3'b001;
    localparam logic [ALU_SEL_W-1:0] OP_AND = 3'b010;
    localparam logic [ALU_SEL_W-1:0] OP_OR  = 3'b011;
    localparam logic [ALU_SEL_W-1:0] OP_XOR = 3'b100;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_HOLD = 2'd2
    } state_e;

endpackage

// File: rtl/alu_cmd_fifo.sv
// Synchronous command FIFO; full/empty come from the registered count only.
module alu_cmd_fifo #(
    parameter int unsigned DATA_W = 11,
    parameter int unsigned DEPTH  = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push_i,
    input  logic [DATA_W-1:0]          wdata_i,
    input  logic                       pop_i,
    output logic [DATA_W-1:0]          rdata_o,
    output logic [$clog2(DEPTH):0]     count_o,
    output logic                       full_o,
    output logic                       empty_o
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q;
    logic [PTR_W-1:0]  rd_ptr_q;
    logic [CNT_W-1:0]  count_q;
    logic              do_push;
    logic              do_pop;

    assign full_o  = (count_q == CNT_W'(DEPTH));
    assign empty_o = (count_q == '0);
    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;
    assign rdata_o = mem_q[rd_ptr_q];
    assign count_o = count_q;

    // Pointer and count update; power-of-two depth lets pointers wrap naturally.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            if (do_pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + CNT_W'(1);
                2'b01:   count_q <= count_q - CNT_W'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    // Storage write; contents are don't-care until pushed, so no reset.
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= wdata_i;
    end

endmodule

// File: rtl/alu_issue_stage.sv
// Issue stage: queues ALU commands, drives them one at a time, registers results.
module alu_issue_stage
    import alu_pkg::*;
#(
    parameter int unsigned WIDTH = ALU_WIDTH,
    parameter int unsigned SEL_W = ALU_SEL_W,
    parameter int unsigned DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   cmd_valid,
    output logic                   cmd_ready,
    input  logic [WIDTH-1:0]       cmd_a,
    input  logic [WIDTH-1:0]       cmd_b,
    input  logic [SEL_W-1:0]       cmd_sel,
    output logic [WIDTH-1:0]       alu_a,
    output logic [WIDTH-1:0]       alu_b,
    output logic [SEL_W-1:0]       alu_sel,
    input  logic [WIDTH-1:0]       alu_result,
    input  logic                   alu_carry,
    output logic                   res_valid,
    input  logic                   res_ready,
    output logic [WIDTH-1:0]       res_data,
    output logic                   res_carry,
    output logic                   res_zero,
    output logic [$clog2(DEPTH):0] occupancy
);

    localparam int unsigned CMD_W = 2 * WIDTH + SEL_W;

    logic [CMD_W-1:0] head;
    logic             fifo_full;
    logic             fifo_empty;
    logic             pop_c;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] alu_a_q, alu_a_d;
    logic [WIDTH-1:0] alu_b_q, alu_b_d;
    logic [SEL_W-1:0] alu_sel_q, alu_sel_d;
    logic             res_valid_q, res_valid_d;
    logic [WIDTH-1:0] res_data_q, res_data_d;
    logic             res_carry_q, res_carry_d;
    logic             res_zero_q, res_zero_d;

    alu_cmd_fifo #(
        .DATA_W (CMD_W),
        .DEPTH  (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push_i  (cmd_valid),
        .wdata_i ({cmd_a, cmd_b, cmd_sel}),
        .pop_i   (pop_c),
        .rdata_o (head),
        .count_o (occupancy),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    assign cmd_ready = !fifo_full;
    assign alu_a     = alu_a_q;
    assign alu_b     = alu_b_q;
    assign alu_sel   = alu_sel_q;
    assign res_valid = res_valid_q;
    assign res_data  = res_data_q;
    assign res_carry = res_carry_q;
    assign res_zero  = res_zero_q;

    // State and datapath registers; reset drops any in-flight command.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            alu_a_q     <= '0;
            alu_b_q     <= '0;
            alu_sel_q   <= '0;
            res_valid_q <= 1'b0;
            res_data_q  <= '0;
            res_carry_q <= 1'b0;
            res_zero_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            alu_a_q     <= alu_a_d;
            alu_b_q     <= alu_b_d;
            alu_sel_q   <= alu_sel_d;
            res_valid_q <= res_valid_d;
            res_data_q  <= res_data_d;
            res_carry_q <= res_carry_d;
            res_zero_q  <= res_zero_d;
        end
    end

    // Issue/capture/hold sequencing; a head is loaded and popped in one step.
    always_comb begin
        state_d     = state_q;
        alu_a_d     = alu_a_q;
        alu_b_d     = alu_b_q;
        alu_sel_d   = alu_sel_q;
        res_valid_d = res_valid_q;
        res_data_d  = res_data_q;
        res_carry_d = res_carry_q;
        res_zero_d  = res_zero_q;
        pop_c       = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (!fifo_empty) begin
                    {alu_a_d, alu_b_d, alu_sel_d} = head;
                    pop_c   = 1'b1;
                    state_d = ST_EXEC;
                end
            end
            ST_EXEC: begin
                res_data_d  = alu_result;
                res_carry_d = alu_carry;
                res_zero_d  = (alu_result == '0);
                res_valid_d = 1'b1;
                state_d     = ST_HOLD;
            end
            ST_HOLD: begin
                if (res_valid_q && res_ready) begin
                    res_valid_d = 1'b0;
                    if (!fifo_empty) begin
                        {alu_a_d, alu_b_d, alu_sel_d} = head;
                        pop_c   = 1'b1;
                        state_d = ST_EXEC;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

endmodule

// File: tb/tb_alu_issue_stage.sv
// Bench for alu_issue_stage with a behavioural ALU and an in-order result model.
module tb_alu_issue_stage;
    import alu_pkg::*;

    logic       clk = 1'b0;
    logic       rst;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [3:0] cmd_a, cmd_b;
    logic [2:0] cmd_sel;
    logic [3:0] alu_a, alu_b;
    logic [2:0] alu_sel;
    logic [3:0] alu_result;
    logic       alu_carry;
    logic       res_valid;
    logic       res_ready;
    logic [3:0] res_data;
    logic       res_carry;
    logic       res_zero;
    logic [2:0] occupancy;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int n_hs  = 0;
    int hs_cyc[$];

    typedef struct {
        logic [3:0] d;
        logic       c;
        logic       z;
    } exp_t;
    exp_t expq[$];

    alu_issue_stage #(.WIDTH(4), .SEL_W(3), .DEPTH(4)) dut (
        .clk        (clk),
        .rst        (rst),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_a      (cmd_a),
        .cmd_b      (cmd_b),
        .cmd_sel    (cmd_sel),
        .alu_a      (alu_a),
        .alu_b      (alu_b),
        .alu_sel    (alu_sel),
        .alu_result (alu_result),
        .alu_carry  (alu_carry),
        .res_valid  (res_valid),
        .res_ready  (res_ready),
        .res_data   (res_data),
        .res_carry  (res_carry),
        .res_zero   (res_zero),
        .occupancy  (occupancy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // The 4-bit combinational ALU sitting behind the stage.
    always_comb begin
        alu_result = 4'h0;
        alu_carry  = 1'b0;
        case (alu_sel)
            OP_ADD: {alu_carry, alu_result} = {1'b0, alu_a} + {1'b0, alu_b};
            OP_SUB: begin
                alu_result = alu_a - alu_b;
                alu_carry  = (alu_a < alu_b);
            end
            OP_AND: alu_result = alu_a & alu_b;
            OP_OR:  alu_result = alu_a | alu_b;
            OP_XOR: alu_result = alu_a ^ alu_b;
            default: begin
                alu_result = 4'h0;
                alu_carry  = 1'b0;
            end
        endcase
    end

    // Expected result of one command, from plain integer arithmetic.
    function automatic exp_t ref_result(input int a, input int b, input int s);
        exp_t e;
        int   v;
        int   cy;
        cy = 0;
        case (s)
            0: begin v = a + b; cy = (v > 15) ? 1 : 0; end
            1: begin v = a - b; cy = (v < 0) ? 1 : 0; end
            2: v = a & b;
            3: v = a | b;
            4: v = a ^ b;
            default: v = 0;
        endcase
        v   = (v + 16) % 16;
        e.d = 4'(v);
        e.c = 1'(cy);
        e.z = (v == 0);
        return e;
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Compare process: in-order scoreboard, hold stability, no orphan results.
    logic       hold_prev = 1'b0;
    logic [3:0] prev_d;
    logic       prev_c, prev_z;
    always @(negedge clk) begin
        if (rst) begin
            expq.delete();
            hold_prev = 1'b0;
        end else begin
            if (hold_prev) begin
                chk("hold_valid", 32'(res_valid), 1);
                chk("hold_data",  32'(res_data),  32'(prev_d));
                chk("hold_carry", 32'(res_carry), 32'(prev_c));
                chk("hold_zero",  32'(res_zero),  32'(prev_z));
            end
            if (cmd_valid && cmd_ready)
                expq.push_back(ref_result(int'(cmd_a), int'(cmd_b), int'(cmd_sel)));
            if (res_valid && res_ready) begin
                n_hs++;
                hs_cyc.push_back(cyc);
                if (expq.size() == 0) begin
                    chk("orphan_result", 32'(res_data), -1);
                end else begin
                    exp_t e;
                    e = expq.pop_front();
                    chk("sb_data",  32'(res_data),  32'(e.d));
                    chk("sb_carry", 32'(res_carry), 32'(e.c));
                    chk("sb_zero",  32'(res_zero),  32'(e.z));
                end
            end
            hold_prev = res_valid && !res_ready;
            prev_d    = res_data;
            prev_c    = res_carry;
            prev_z    = res_zero;
        end
    end

    // Offer one command until accepted; returns just after the accepting edge.
    task automatic push_cmd(input logic [3:0] a, input logic [3:0] b, input logic [2:0] s);
        bit ok;
        ok        = 1'b0;
        cmd_a     = a;
        cmd_b     = b;
        cmd_sel   = s;
        cmd_valid = 1'b1;
        for (int i = 0; i < 40 && !ok; i++) begin
            @(negedge clk);
            ok = cmd_ready;
            @(posedge clk);
            #1;
        end
        cmd_valid = 1'b0;
        if (!ok) chk("push_timeout", 0, 1);
    endtask

    // Advance to the first negedge with res_valid high, bounded.
    task automatic wait_valid(input string name);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 40 && !ok; i++) begin
            @(negedge clk);
            ok = res_valid;
        end
        if (!ok) chk(name, 0, 1);
    endtask

    task automatic release_one();
        @(posedge clk);
        #1;
        res_ready = 1'b1;
        @(posedge clk);
        #1;
        res_ready = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        int idx;
        int hs0;
        rst       = 1'b1;
        cmd_valid = 1'b0;
        cmd_a     = 4'h0;
        cmd_b     = 4'h0;
        cmd_sel   = 3'h0;
        res_ready = 1'b0;
        idle(2);
        rst = 1'b0;

        // Reset state
        @(negedge clk);
        chk("rst_valid", 32'(res_valid), 0);
        chk("rst_data",  32'(res_data),  0);
        chk("rst_carry", 32'(res_carry), 0);
        chk("rst_zero",  32'(res_zero),  0);
        chk("rst_occ",   32'(occupancy), 0);
        chk("rst_alu",   32'({alu_a, alu_b, alu_sel}), 0);
        chk("rst_ready", 32'(cmd_ready), 1);
        @(posedge clk); #1;

        // 1: add 7+9, two-edge latency
        res_ready = 1'b1;
        push_cmd(4'd7, 4'd9, OP_ADD);
        @(negedge clk); chk("t1_lat_n0", 32'(res_valid), 0);
        @(negedge clk); chk("t1_lat_n1", 32'(res_valid), 0);
        @(negedge clk); chk("t1_lat_n2", 32'(res_valid), 1);
        chk("t1_data",  32'(res_data),  0);
        chk("t1_carry", 32'(res_carry), 1);
        chk("t1_zero",  32'(res_zero),  1);
        idle(3);

        // 2: sub 3-5
        push_cmd(4'd3, 4'd5, OP_SUB);
        wait_valid("t2_timeout");
        chk("t2_data",  32'(res_data),  14);
        chk("t2_carry", 32'(res_carry), 1);
        chk("t2_zero",  32'(res_zero),  0);
        idle(3);

        // 3: fill with res_ready low, then drain in order at 1 per 2 cycles
        res_ready = 1'b0;
        idx = 0;
        for (int t = 0; t < 9; t++) begin
            cmd_valid = (idx < 6);
            cmd_a     = 4'(idx + 1);
            cmd_b     = 4'h5;
            cmd_sel   = OP_XOR;
            @(negedge clk);
            if (cmd_valid && cmd_ready) idx++;
            @(posedge clk);
            #1;
        end
        cmd_valid = 1'b0;
        chk("t3_accepted", idx, 5);
        @(negedge clk);
        chk("t3_ready", 32'(cmd_ready), 0);
        chk("t3_occ",   32'(occupancy), 4);
        chk("t3_first", 32'(res_data),  4);
        @(posedge clk); #1;
        hs_cyc.delete();
        res_ready = 1'b1;
        idle(14);
        chk("t3_nres", hs_cyc.size(), 5);
        for (int i = 1; i < hs_cyc.size(); i++)
            chk("t3_gap", hs_cyc[i] - hs_cyc[i-1], 2);

        // 4: stall while valid; outputs stay put
        res_ready = 1'b0;
        push_cmd(4'd5, 4'd2, OP_ADD);
        wait_valid("t4_timeout");
        repeat (3) @(negedge clk);
        chk("t4_valid", 32'(res_valid), 1);
        chk("t4_data",  32'(res_data),  7);
        chk("t4_carry", 32'(res_carry), 0);
        chk("t4_zero",  32'(res_zero),  0);
        release_one();

        // 5: and, then an undefined opcode
        push_cmd(4'hC, 4'hA, OP_AND);
        push_cmd(4'h5, 4'h6, 3'b111);
        wait_valid("t5a_timeout");
        chk("t5a_data", 32'(res_data), 8);
        chk("t5a_zero", 32'(res_zero), 0);
        release_one();
        wait_valid("t5b_timeout");
        chk("t5b_data",  32'(res_data),  0);
        chk("t5b_carry", 32'(res_carry), 0);
        chk("t5b_zero",  32'(res_zero),  1);
        release_one();
        idle(3);

        // 6: reset with three queued and one held
        push_cmd(4'h1, 4'h1, OP_ADD);
        push_cmd(4'h2, 4'h1, OP_ADD);
        push_cmd(4'h3, 4'h1, OP_ADD);
        push_cmd(4'h4, 4'h1, OP_ADD);
        @(negedge clk);
        chk("t6_pre_occ",   32'(occupancy), 3);
        chk("t6_pre_valid", 32'(res_valid), 1);
        chk("t6_pre_data",  32'(res_data),  2);
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk("t6_valid", 32'(res_valid), 0);
        chk("t6_occ",   32'(occupancy), 0);
        chk("t6_alu",   32'({alu_a, alu_b, alu_sel}), 0);
        hs0 = n_hs;
        res_ready = 1'b1;
        idle(10);
        chk("t6_no_stale", n_hs - hs0, 0);

        chk("final_drain", expq.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
